cache_fill_fsm: RTL and testbench

//  Miss-handling controller between the pipeline's I/D caches and the multi-cycle main memory.
//  On a cache miss it stalls the pipeline via fsm_busy and fetches one block as BLOCK_WORDS

---
 rtl/cache_fill_fsm.sv | 127 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline, streams one block from memory into the data array, then writes the tag.
// Optional CACHE_FILL_PERF_EN adds a saturating completed-fill counter output (fill_count).
module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int WORD_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  input  logic                           memory_data_valid,
  input  logic [WORD_W-1:0]              memory_data,
  output logic                           fsm_busy,
  output logic                           mem_read_en,
  output logic [ADDR_W-1:0]              memory_address,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_index,
  output logic [WORD_W-1:0]              fill_data,
`ifdef CACHE_FILL_PERF_EN
  output logic [15:0]                    fill_count,
`endif
  output logic                           write_tag_array
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

  // Handshake: memory takes one request per cycle whenever mem_read_en=1 (no ready);
  // memory_data_valid marks one returned word per cycle, in request order.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    recv_cnt_q, recv_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        // Combinational stall so the pipeline freezes in the miss cycle itself.
        fsm_busy = miss_detected & ~rst;
        if (miss_detected) begin
          base_d      = miss_address & ~OFF_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt_q < CNT_FULL) begin
          mem_read_en    = 1'b1;
          memory_address = base_q + (ADDR_W'(issue_cnt_q) << 1);
          issue_cnt_d    = issue_cnt_q + 1'b1;
        end
        if (memory_data_valid && (recv_cnt_q < CNT_FULL)) begin
          write_data_array = 1'b1;
          word_index       = recv_cnt_q[IDX_W-1:0];
          fill_data        = memory_data;
          recv_cnt_d       = recv_cnt_q + 1'b1;
          if (recv_cnt_q == CNT_LAST) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_FILL_PERF_EN
  logic [15:0] fill_count_q, fill_count_d;

  always_comb begin
    fill_count_d = fill_count_q;
    if (write_tag_array && (fill_count_q != 16'hFFFF)) begin
      fill_count_d = fill_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count_q <= '0;
    end else begin
      fill_count_q <= fill_count_d;
    end
  end

  assign fill_count = fill_count_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: randomized in-order memory model with variable latency
// and a scoreboard of expected fill words.
module tb_cache_fill_fsm;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;
  localparam int BW     = 8;
  localparam int IDX_W  = 3;
  localparam logic [ADDR_W-1:0] BLK_MASK = 16'h000F;

  logic              clk;
  logic              rst;
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [WORD_W-1:0] memory_data;
  logic              fsm_busy;
  logic              mem_read_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  word_index;
  logic [WORD_W-1:0] fill_data;
  logic              write_tag_array;
`ifdef CACHE_FILL_PERF_EN
  logic [15:0]       fill_count;
`endif

  int checks;
  int errors;

  logic [WORD_W-1:0] exp_q[$];
  int                due_q[$];

  cache_fill_fsm #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_WORDS(BW)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .fill_data         (fill_data),
`ifdef CACHE_FILL_PERF_EN
    .fill_count        (fill_count),
`endif
    .write_tag_array   (write_tag_array)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One block fill. Cycle 0 is the miss cycle; memory answers each request after lat (+jitter) cycles,
  // in request order. Returns early (at input-drive time) once abort_at words have been written.
  task automatic run_fill(input logic [ADDR_W-1:0] addr, input int lat, input bit jitter,
                          input bit fixed, input bit hold_miss, input int abort_at,
                          output int first_wr, output int tag_cyc);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] exp_addr;
    int issued, recvd, last_due, due, t;
    bit v, done;
    base = addr & ~BLK_MASK;
    issued = 0; recvd = 0; last_due = 0; first_wr = -1; tag_cyc = -1; done = 0;
    miss_detected = 1'b1; miss_address = addr; memory_data_valid = 1'b0;
    #1;
    checks++;
    if (fsm_busy !== 1'b1) begin
      errors++; $display("FAIL miss_cycle_busy addr=%h got=%b exp=1", addr, fsm_busy);
    end
    @(posedge clk); #1;
    t = 1;
    while (!done) begin
      if (abort_at >= 0 && recvd == abort_at) return;
      if (t > 100) begin
        errors++; $display("FAIL fill_timeout addr=%h recvd=%0d exp=%0d", addr, recvd, BW);
        return;
      end
      miss_detected = hold_miss;
      miss_address  = hold_miss ? 16'h4000 : 16'($urandom);
      v = (due_q.size() > 0) && (due_q[0] == t);
      memory_data_valid = v;
      memory_data = v ? exp_q[0] : 16'($urandom);
      #1;
      checks++;
      if (fsm_busy !== 1'b1) begin
        errors++; $display("FAIL fill_busy t=%0d got=%b exp=1", t, fsm_busy);
      end
      checks++;
      if (mem_read_en !== (issued < BW)) begin
        errors++; $display("FAIL read_en t=%0d got=%b exp=%b", t, mem_read_en, issued < BW);
      end
      if (issued < BW) begin
        exp_addr = base + 16'(2 * issued);
        checks++;
        if (memory_address !== exp_addr) begin
          errors++; $display("FAIL req_addr t=%0d got=%h exp=%h", t, memory_address, exp_addr);
        end
      end
      checks++;
      if (write_data_array !== v) begin
        errors++; $display("FAIL data_write t=%0d got=%b exp=%b", t, write_data_array, v);
      end
      checks++;
      if (write_tag_array !== (v && recvd == BW - 1)) begin
        errors++; $display("FAIL tag_write t=%0d got=%b exp=%b", t, write_tag_array, v && recvd == BW - 1);
      end
      if (v) begin
        checks++;
        if (word_index !== 3'(recvd)) begin
          errors++; $display("FAIL word_index t=%0d got=%0d exp=%0d", t, word_index, recvd);
        end
        checks++;
        if (fill_data !== exp_q[0]) begin
          errors++; $display("FAIL fill_data t=%0d got=%h exp=%h", t, fill_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        if (first_wr < 0) first_wr = t;
        recvd++;
        if (recvd == BW) begin
          tag_cyc = t;
          done = 1;
        end
      end
      if (issued < BW) begin
        due = t + lat + (jitter ? int'($urandom_range(0, 2)) : 0);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        due_q.push_back(due);
        exp_q.push_back(fixed ? 16'hA000 + 16'(issued) : 16'($urandom));
        issued++;
      end
      @(posedge clk); #1;
      t++;
    end
    if (!hold_miss) begin
      miss_detected = 1'b0; memory_data_valid = 1'b0;
      #1;
      checks++;
      if ({fsm_busy, mem_read_en, write_data_array} !== 3'b000) begin
        errors++; $display("FAIL after_fill_idle busy/rd/wr got=%b exp=000", {fsm_busy, mem_read_en, write_data_array});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; miss_detected = 1'b1; miss_address = 16'h1234;
    memory_data_valid = 1'b1; memory_data = 16'hBEEF;
    #1;
    checks++;
    if ({fsm_busy, mem_read_en, memory_address, write_data_array, word_index, fill_data, write_tag_array} !== '0) begin
      errors++; $display("FAIL reset_outputs busy=%b rd=%b addr=%h wr=%b idx=%0d data=%h tag=%b exp=all0",
                         fsm_busy, mem_read_en, memory_address, write_data_array, word_index, fill_data, write_tag_array);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; miss_detected = 1'b0;
    #1;
    checks++;
    if ({fsm_busy, mem_read_en, memory_address, write_data_array, word_index, fill_data, write_tag_array} !== '0) begin
      errors++; $display("FAIL post_reset_idle busy=%b rd=%b wr=%b data=%h tag=%b exp=all0",
                         fsm_busy, mem_read_en, write_data_array, fill_data, write_tag_array);
    end
    memory_data_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_fill;
    int fw, tc;
    run_fill(16'h1236, 4, 1'b0, 1'b1, 1'b0, -1, fw, tc);
    checks++;
    if (fw !== 5) begin
      errors++; $display("FAIL first_write_cycle got=%0d exp=5", fw);
    end
    checks++;
    if (tc !== 12) begin
      errors++; $display("FAIL tag_cycle got=%0d exp=12", tc);
    end
  endtask

  task automatic test_idle_spurious;
    miss_detected = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memory_data_valid = 1'b1; memory_data = 16'hDEAD;
      #1;
      checks++;
      if ({fsm_busy, write_data_array, write_tag_array, mem_read_en} !== 4'b0000) begin
        errors++; $display("FAIL idle_spurious busy/wr/tag/rd got=%b exp=0000",
                           {fsm_busy, write_data_array, write_tag_array, mem_read_en});
      end
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_miss_during_fill;
    int fw, tc;
    run_fill(16'h2468, 3, 1'b1, 1'b0, 1'b1, -1, fw, tc);
    run_fill(16'h4000, 2, 1'b0, 1'b0, 1'b0, -1, fw, tc);
  endtask

  task automatic test_top_of_memory;
    int fw, tc;
    run_fill(16'hFFFE, 5, 1'b1, 1'b0, 1'b0, -1, fw, tc);
  endtask

  task automatic test_random_fills;
    int fw, tc;
    for (int n = 0; n < 5; n++) begin
      run_fill(16'($urandom), int'($urandom_range(1, 6)), 1'b1, 1'b0, 1'b0, -1, fw, tc);
    end
  endtask

  task automatic test_reset_mid_fill;
    int fw, tc;
    run_fill(16'h3A5C, 3, 1'b0, 1'b0, 1'b0, 3, fw, tc);
    rst = 1'b1; miss_detected = 1'b1; memory_data_valid = 1'b1; memory_data = 16'h5555;
    #1;
    checks++;
    if ({fsm_busy, mem_read_en, memory_address, write_data_array, word_index, fill_data, write_tag_array} !== '0) begin
      errors++; $display("FAIL mid_fill_reset busy=%b rd=%b wr=%b data=%h tag=%b exp=all0",
                         fsm_busy, mem_read_en, write_data_array, fill_data, write_tag_array);
    end
    @(posedge clk); #1;
    rst = 1'b0; miss_detected = 1'b0;
    #1;
    checks++;
    if ({fsm_busy, mem_read_en, memory_address, write_data_array, word_index, fill_data, write_tag_array} !== '0) begin
      errors++; $display("FAIL after_abort_idle busy=%b rd=%b wr=%b data=%h tag=%b exp=all0",
                         fsm_busy, mem_read_en, write_data_array, fill_data, write_tag_array);
    end
    memory_data_valid = 1'b0;
    due_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    run_fill(16'h7F02, 4, 1'b1, 1'b0, 1'b0, -1, fw, tc);
  endtask

`ifdef CACHE_FILL_PERF_EN
  task automatic test_perf;
    int fw, tc;
    test_reset;
    checks++;
    if (fill_count !== 16'd0) begin
      errors++; $display("FAIL perf_reset got=%0d exp=0", fill_count);
    end
    for (int n = 0; n < 3; n++) begin
      run_fill(16'($urandom), 2, 1'b0, 1'b0, 1'b0, -1, fw, tc);
    end
    checks++;
    if (fill_count !== 16'd3) begin
      errors++; $display("FAIL perf_count got=%0d exp=3", fill_count);
    end
    force dut.fill_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.fill_count_q;
    run_fill(16'h0100, 2, 1'b0, 1'b0, 1'b0, -1, fw, tc);
    checks++;
    if (fill_count !== 16'hFFFF) begin
      errors++; $display("FAIL perf_saturate got=%h exp=ffff", fill_count);
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; miss_detected = 1'b0; miss_address = '0;
    memory_data_valid = 1'b0; memory_data = '0;
    #2;
    test_reset;
    test_basic_fill;
    test_idle_spurious;
    test_miss_during_fill;
    test_top_of_memory;
    test_random_fills;
    test_reset_mid_fill;
`ifdef CACHE_FILL_PERF_EN
    test_perf;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
